// File: rtl/instr_axil_rd_master.sv
// instr_axil_rd_master
//   Turns each OBI instruction fetch into a single AR/R read on the simplified
//   AXI-lite read channel. Only one read is outstanding at a time, so responses
//   come back in order. If a read stalls too long, it is aborted and an error
//   response is returned.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   obi_req/obi_addr      fetch request and byte address from the core
//   obi_gnt               address phase accepted (combinational in IDLE)
//   obi_rvalid/rdata/err  one-cycle response pulse; rdata and err hold afterwards
//   araddr/arvalid/arready    read address channel (araddr is word aligned)
//   rdata/rvalid/rready       read data channel
//   timeout_clr           clears timeout_sticky
//   timeout_sticky        set by any timeout abort
//   busy                  a transaction is in flight
module instr_axil_rd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0013,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obi_req,
  input  logic [31:0] obi_addr,
  output logic        obi_gnt,
  output logic        obi_rvalid,
  output logic [31:0] obi_rdata,
  output logic        obi_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  input  logic        timeout_clr,
  output logic        timeout_sticky,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TimeoutLastInt = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TimeoutLastInt);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [31:0]       araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              obi_rvalid_q, obi_rvalid_d;
  logic [31:0]       obi_rdata_q, obi_rdata_d;
  logic              obi_err_q, obi_err_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ar_hs, r_hs, timeout_hit, abort;
  logic [CNT_W-1:0]  cnt_inc;

  // In IDLE rready stays high so that a late or stale rvalid is drained silently.
  assign rready  = (state_q != StAr);
  assign obi_gnt = (state_q == StIdle) && obi_req;
  assign busy    = (state_q != StIdle);

  assign ar_hs   = arvalid_q && arready;
  assign r_hs    = rvalid && rready;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  // cnt_q counts the cycles already spent in AR+R. This cycle is therefore cycle
  // cnt_q+1, and it is the last one allowed when cnt_q reaches TIMEOUT_CYCLES-1.
  assign timeout_hit = TimeoutEn && (cnt_q >= TimeoutLast);

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    obi_rvalid_d = 1'b0;
    obi_rdata_d  = obi_rdata_q;
    obi_err_d    = obi_err_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q && !timeout_clr;
    abort        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (obi_req) begin
          araddr_d  = {obi_addr[31:2], 2'b00};
          arvalid_d = 1'b1;
          cnt_d     = '0;
          state_d   = StAr;
        end
      end
      StAr: begin
        // A handshake takes priority over a timeout that hits in the same cycle.
        if (ar_hs) begin
          arvalid_d = 1'b0;
          cnt_d     = cnt_inc;
          state_d   = StR;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StR: begin
        if (r_hs) begin
          obi_rvalid_d = 1'b1;
          obi_rdata_d  = rdata;
          obi_err_d    = 1'b0;
          state_d      = StIdle;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    // arvalid is dropped without a handshake here. This is a deliberate recovery
    // path for a responder that never answers.
    if (abort) begin
      arvalid_d    = 1'b0;
      state_d      = StIdle;
      obi_rvalid_d = 1'b1;
      obi_err_d    = 1'b1;
      obi_rdata_d  = ERR_DATA;
      sticky_d     = 1'b1;  // a new abort overrides a simultaneous clear
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      obi_rvalid_q <= 1'b0;
      obi_rdata_q  <= '0;
      obi_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      obi_rvalid_q <= obi_rvalid_d;
      obi_rdata_q  <= obi_rdata_d;
      obi_err_q    <= obi_err_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign araddr         = araddr_q;
  assign arvalid        = arvalid_q;
  assign obi_rvalid     = obi_rvalid_q;
  assign obi_rdata      = obi_rdata_q;
  assign obi_err        = obi_err_q;
  assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_instr_axil_rd_master.sv
// Directed bench for instr_axil_rd_master. There are two instances:
//   u_a uses TIMEOUT_CYCLES=16 and u_b uses TIMEOUT_CYCLES=4.
// Both instances share all inputs. A simple ROM responder follows whichever
// instance sel_b selects.
module tb_instr_axil_rd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req;
  logic [31:0] obi_addr;
  logic        arready;
  logic        timeout_clr;
  logic        rvalid;
  logic [31:0] rd_q;

  logic        gnt_a, orv_a, err_a, arv_a, rrdy_a, stk_a, busy_a;
  logic [31:0] ord_a, ara_a;
  logic        gnt_b, orv_b, err_b, arv_b, rrdy_b, stk_b, busy_b;
  logic [31:0] ord_b, ara_b;

  logic        sel_b;
  logic        gnt_s, orv_s, err_s, arv_s, rrdy_s, stk_s, busy_s;
  logic [31:0] ord_s, ara_s;

  int n_cmp  = 0;
  int n_fail = 0;
  int r_delay;

  always #5 clk = ~clk;

  instr_axil_rd_master #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'h0000_0013), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .obi_req(obi_req), .obi_addr(obi_addr), .obi_gnt(gnt_a),
    .obi_rvalid(orv_a), .obi_rdata(ord_a), .obi_err(err_a), .araddr(ara_a), .arvalid(arv_a),
    .arready(arready), .rdata(rd_q), .rvalid(rvalid), .rready(rrdy_a),
    .timeout_clr(timeout_clr), .timeout_sticky(stk_a), .busy(busy_a)
  );

  instr_axil_rd_master #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'h0000_0013), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .obi_req(obi_req), .obi_addr(obi_addr), .obi_gnt(gnt_b),
    .obi_rvalid(orv_b), .obi_rdata(ord_b), .obi_err(err_b), .araddr(ara_b), .arvalid(arv_b),
    .arready(arready), .rdata(rd_q), .rvalid(rvalid), .rready(rrdy_b),
    .timeout_clr(timeout_clr), .timeout_sticky(stk_b), .busy(busy_b)
  );

  assign gnt_s  = sel_b ? gnt_b  : gnt_a;
  assign orv_s  = sel_b ? orv_b  : orv_a;
  assign err_s  = sel_b ? err_b  : err_a;
  assign arv_s  = sel_b ? arv_b  : arv_a;
  assign rrdy_s = sel_b ? rrdy_b : rrdy_a;
  assign stk_s  = sel_b ? stk_b  : stk_a;
  assign busy_s = sel_b ? busy_b : busy_a;
  assign ord_s  = sel_b ? ord_b  : ord_a;
  assign ara_s  = sel_b ? ara_b  : ara_a;

  function automatic logic [31:0] rom(input logic [29:0] idx);
    return 32'h1000_0000 + {2'b00, idx} * 32'h0000_0111;
  endfunction

  // ROM responder. Data comes r_delay cycles after the cycle that follows the
  // AR handshake.
  logic pend = 1'b0;
  int   wcnt = 0;
  always @(posedge clk) begin
    if (arv_s && arready) begin
      pend <= 1'b1;
      wcnt <= r_delay;
      rd_q <= rom(ara_s[31:2]);
    end else if (pend) begin
      if (wcnt != 0) wcnt <= wcnt - 1;
      else if (rrdy_s) pend <= 1'b0;
    end
  end
  assign rvalid = pend && (wcnt == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one fetch and check grant, araddr, latency, data and error.
  // Latency is measured in cycles from the grant to obi_rvalid.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                          input logic exp_e, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    obi_req  = 1'b1;
    obi_addr = addr;
    #1;
    chk({tag, ".gnt"}, 32'(gnt_s), 32'd1);
    @(negedge clk);
    obi_req = 1'b0;
    chk({tag, ".arvalid"}, 32'(arv_s), 32'd1);
    chk({tag, ".araddr"}, ara_s, {addr[31:2], 2'b00});
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (orv_s) seen = 1'b1;
    end
    chk({tag, ".rvalid_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, ord_s, exp_d);
    chk({tag, ".err"}, 32'(err_s), 32'(exp_e));
    @(negedge clk);
    chk({tag, ".rvalid_pulse"}, 32'(orv_s), 32'd0);
    chk({tag, ".rdata_hold"}, ord_s, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; obi_req = 1'b0; obi_addr = '0; arready = 1'b1;
    timeout_clr = 1'b0; r_delay = 0; sel_b = 1'b0;
    #12;
    chk("rst.arvalid", 32'(arv_a), 32'd0);
    chk("rst.araddr", ara_a, 32'd0);
    chk("rst.obi_rvalid", 32'(orv_a), 32'd0);
    chk("rst.obi_rdata", ord_a, 32'd0);
    chk("rst.obi_err", 32'(err_a), 32'd0);
    chk("rst.sticky", 32'(stk_a), 32'd0);
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.gnt", 32'(gnt_a), 32'd0);
    chk("rst.rready", 32'(rrdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single zero-wait fetch
    do_fetch("t1", 32'h0000_0010, rom(30'd4), 1'b0, 3);

    // 2: obi_req held for 8 fetches. The bench expects one grant and one response
    //    every 3 cycles.
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      obi_req  = (c < 24);
      obi_addr = 32'(c / 3) * 32'd4;
      #1;
      chk($sformatf("t2.gnt[%0d]", c), 32'(gnt_a), 32'((c % 3 == 0) && (c < 24)));
      if (c % 3 == 0 && c > 0) begin
        chk($sformatf("t2.rvalid[%0d]", c), 32'(orv_a), 32'd1);
        chk($sformatf("t2.rdata[%0d]", c), ord_a, rom(30'(c / 3 - 1)));
        chk($sformatf("t2.err[%0d]", c), 32'(err_a), 32'd0);
      end else begin
        chk($sformatf("t2.rvalid[%0d]", c), 32'(orv_a), 32'd0);
      end
    end
    chk("t2.sticky", 32'(stk_a), 32'd0);

    // 3: an unaligned address is word aligned on araddr
    do_fetch("t3", 32'h0000_0043, rom(30'h10), 1'b0, 3);

    // 4: arready held low. arvalid should stay high for 16 cycles, then an
    //    error response follows.
    @(negedge clk);
    arready  = 1'b0;
    obi_req  = 1'b1;
    obi_addr = 32'h0000_0100;
    #1;
    chk("t4.gnt", 32'(gnt_a), 32'd1);
    @(negedge clk);
    obi_req = 1'b0;
    n = 0;
    while (arv_a && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4.arvalid_cycles", 32'(n), 32'd16);
    chk("t4.obi_rvalid", 32'(orv_a), 32'd1);
    chk("t4.obi_err", 32'(err_a), 32'd1);
    chk("t4.obi_rdata", ord_a, 32'h0000_0013);
    chk("t4.sticky", 32'(stk_a), 32'd1);
    chk("t4.busy", 32'(busy_a), 32'd0);
    arready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4.sticky_held", 32'(stk_a), 32'd1);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("t4.sticky_clr", 32'(stk_a), 32'd0);

    // 5: u_b with TIMEOUT_CYCLES=4. The read data arrives 5 cycles late, so the
    //    read aborts after 4 cycles.
    sel_b   = 1'b1;
    r_delay = 5;
    do_fetch("t5", 32'h0000_0020, 32'h0000_0013, 1'b1, 5);
    r_delay = 0;
    chk("t5.sticky", 32'(stk_b), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5.late_discard[%0d]", i), 32'(orv_b), 32'd0);
      chk($sformatf("t5.idle[%0d]", i), 32'(busy_b), 32'd0);
    end
    do_fetch("t5b", 32'h0000_0024, rom(30'd9), 1'b0, 3);

    // 6: reset asserted while u_a is in the R state
    sel_b   = 1'b0;
    r_delay = 3;
    @(negedge clk);
    obi_req  = 1'b1;
    obi_addr = 32'h0000_0030;
    #1;
    chk("t6.gnt", 32'(gnt_a), 32'd1);
    @(negedge clk);
    obi_req = 1'b0;
    @(negedge clk);
    chk("t6.in_r_busy", 32'(busy_a), 32'd1);
    chk("t6.in_r_arvalid", 32'(arv_a), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6.arvalid", 32'(arv_a), 32'd0);
    chk("t6.araddr", ara_a, 32'd0);
    chk("t6.obi_rvalid", 32'(orv_a), 32'd0);
    chk("t6.obi_rdata", ord_a, 32'd0);
    chk("t6.obi_err", 32'(err_a), 32'd0);
    chk("t6.busy", 32'(busy_a), 32'd0);
    chk("t6.sticky_b", 32'(stk_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    r_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t6.no_resp[%0d]", i), 32'(orv_a), 32'd0);
    end
    do_fetch("t6b", 32'h0000_0030, rom(30'd12), 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
